// File: rtl/codeword_buffer_ctrl.sv
// Frame buffer controller: loads FRAME_LEN samples into an external memory, then drains them in order.
// Optional feature macro CWB_REPLAY_EN adds a HOLD state where `replay` re-emits the stored frame.
module codeword_buffer_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 5,
  parameter int FRAME_LEN = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              replay,
  output logic              frame_loaded,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_o_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake rule on both streams: a transfer happens in a cycle where valid && ready are both high
  // at the rising edge; once raised, out_valid stays high and out_data stays stable until that transfer.

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] FLEN = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_head;
  logic [1:0]        r_count;
  logic              r_frame_loaded;

  logic       w_in_ready;
  logic       w_replay_go;
  logic       w_wr_fire;
  logic       w_rd_fire;
  logic       w_pop;
  logic       w_push;
  logic       w_last_pop;
  logic       w_wr_slot;
  logic [2:0] w_occ;

  assign w_in_ready = (r_state == S_LOAD) || (r_state == S_HOLD);

`ifdef CWB_REPLAY_EN
  assign w_replay_go = (r_state == S_HOLD) && replay;
`else
  logic w_unused_replay;
  assign w_unused_replay = replay;
  assign w_replay_go     = 1'b0;
`endif

  assign w_wr_fire = in_valid && w_in_ready && !w_replay_go;
  assign w_pop     = (r_count != 2'd0) && out_ready;
  assign w_push    = r_inflight;
  assign w_wr_slot = r_head ^ r_count[0];

  // Slots committed for the cycle after this one: buffered plus in flight, minus what leaves now.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_fire = (r_state == S_DRAIN) && (r_rd_ptr < FLEN) && (w_occ < 3'd2);

  // The final sample leaves when every read is issued, none is in flight and one is buffered.
  assign w_last_pop = w_pop && (r_rd_ptr == FLEN) && !r_inflight && (r_count == 2'd1);

  assign mem_rw    = w_wr_fire;
  assign mem_o_en  = w_rd_fire;
  assign mem_addr  = w_wr_fire ? r_wr_ptr[ADDR_W-1:0] :
                     w_rd_fire ? r_rd_ptr[ADDR_W-1:0] : '0;
  assign mem_wdata = w_wr_fire ? in_data : '0;

  assign in_ready     = w_in_ready;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_fifo[r_head];
  assign frame_loaded = r_frame_loaded;
  assign dbg_state    = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_LOAD;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_inflight     <= 1'b0;
      r_fifo[0]      <= '0;
      r_fifo[1]      <= '0;
      r_head         <= 1'b0;
      r_count        <= 2'd0;
      r_frame_loaded <= 1'b0;
    end else begin
      r_frame_loaded <= 1'b0;
      r_inflight     <= w_rd_fire;
      if (w_push) r_fifo[w_wr_slot] <= mem_rdata;
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + ONE;

      case (r_state)
        S_LOAD: begin
          if (w_wr_fire) begin
            if (r_wr_ptr == LAST) begin
              r_wr_ptr       <= '0;
              r_state        <= S_DRAIN;
              r_frame_loaded <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + ONE;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_rd_ptr <= '0;
`ifdef CWB_REPLAY_EN
            r_state  <= S_HOLD;
`else
            r_state  <= S_LOAD;
`endif
          end
        end
        S_HOLD: begin
          if (w_replay_go) begin
            r_rd_ptr <= '0;
            r_state  <= S_DRAIN;
          end else if (w_wr_fire) begin
            r_wr_ptr <= ONE;
            r_state  <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_codeword_buffer_ctrl.sv
// Self-checking bench for codeword_buffer_ctrl: vector table, directed corner sequences and random frames
// scored against a frame-level queue model.
module tb_codeword_buffer_ctrl;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 5;
  localparam int FRAME_LEN = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              replay;
  logic              frame_loaded;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic              mem_o_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  codeword_buffer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .replay(replay),
    .frame_loaded(frame_loaded), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_o_en(mem_o_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Synchronous single-port memory: read data appears the cycle after the read strobe.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= mem_wdata;
    else if (mem_o_en) mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases follow frame-level events (frame fully accepted, frame fully emitted).
  typedef enum int {PH_LOAD, PH_DRAIN, PH_HOLD} ph_t;
  ph_t               ph = PH_LOAD;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] frame_q[$];
  logic [DATA_W-1:0] last_frame[$];
  int                wr_idx = 0, drained = 0, issued = 0, pops = 0;
  logic              fl_exp = 1'b0;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      ph = PH_LOAD; wr_idx = 0; drained = 0; issued = 0; pops = 0;
      fl_exp = 1'b0; stall_prev = 1'b0;
      exp_q.delete(); frame_q.delete();
    end else begin
      check("in_ready", in_ready, ph != PH_DRAIN);
      check("frame_loaded", frame_loaded, fl_exp);
      fl_exp = 1'b0;
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, stall_data);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (ph != PH_DRAIN) check("no_read_outside_drain", mem_o_en, 0);

      if (ph == PH_HOLD && replay) begin
        check("replay_no_write", mem_rw, 0);
        exp_q = last_frame;
        ph = PH_DRAIN;
        drained = 0;
      end else if (in_valid && ph != PH_DRAIN) begin
        check("wr_rw", mem_rw, 1);
        check("wr_addr", mem_addr, wr_idx);
        check("wr_data", mem_wdata, in_data);
        frame_q.push_back(in_data);
        wr_idx++;
        ph = PH_LOAD;
        if (wr_idx == FRAME_LEN) begin
          exp_q = frame_q;
          last_frame = frame_q;
          frame_q.delete();
          wr_idx = 0;
          ph = PH_DRAIN;
          drained = 0;
          fl_exp = 1'b1;
        end
      end else begin
        check("no_write", mem_rw, 0);
      end

      if (mem_o_en) issued++;
      if (out_valid && out_ready) begin
        pops++;
        drained++;
        if (exp_q.size() == 0) check("unexpected_pop", out_data, 32'hffff_ffff);
        else check("out_data", out_data, exp_q.pop_front());
        if (drained == FRAME_LEN) begin
`ifdef CWB_REPLAY_EN
          ph = PH_HOLD;
`else
          ph = PH_LOAD;
`endif
        end
      end
      if (mem_o_en) check("outstanding_le2", 32'(issued - pops > 2), 0);
    end
  end

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              exp_rw;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
  } vec_t;
  vec_t vecs [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int mode, input bit gaps);
    int acc = 0;
    int n = 0;
    while (acc < FRAME_LEN && n < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       in_data = DATA_W'(acc);
        1:       in_data = DATA_W'($urandom);
        default: in_data = DATA_W'(5);
      endcase
      #1;
      if (in_valid && in_ready) acc++;
      step();
      n++;
    end
    in_valid = 1'b0;
    check("load_done", acc, FRAME_LEN);
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while ((ph == PH_DRAIN || exp_q.size() != 0) && n < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    out_ready = 1'b1;
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].v         = (i % 2 == 0);
      vecs[i].d         = vecs[i].v ? DATA_W'(31 - i / 2) : DATA_W'($urandom);
      vecs[i].exp_rw    = vecs[i].v;
      vecs[i].exp_addr  = vecs[i].v ? ADDR_W'(i / 2) : '0;
      vecs[i].exp_wdata = vecs[i].v ? DATA_W'(31 - i / 2) : '0;
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; replay = 1'b0;
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_loaded", frame_loaded, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_o_en", mem_o_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    step();

    // Basic load and drain with exact latency.
    load_frame(0, 1'b0);
    check("t1_frame_loaded", frame_loaded, 1);
    check("t1_first_read", mem_o_en, 1);
    step();
    check("t2_no_valid_yet", out_valid, 0);
    step();
    check("t3_first_valid", out_valid, 1);
    check("t3_first_data", out_data, 0);
    for (int i = 1; i < FRAME_LEN; i++) begin
      step();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, i);
    end
    step();
    check("ready_after_drain", in_ready, 1);
    check("idle_after_drain", out_valid, 0);

    // Gapped input from the vector table.
    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      #1;
      check("vec_rw", mem_rw, vecs[i].exp_rw);
      check("vec_addr", mem_addr, vecs[i].exp_addr);
      check("vec_wdata", mem_wdata, vecs[i].exp_wdata);
      step();
    end
    in_valid = 1'b0;
    wait_drain(1'b0);

    // Output backpressure: five stalled cycles once the first sample is presented.
    load_frame(1, 1'b0);
    repeat (2) step();
    check("bp_valid", out_valid, 1);
    out_ready = 1'b0;
    repeat (5) step();
    wait_drain(1'b0);

    // Reset after three samples have left.
    load_frame(1, 1'b1);
    for (int n = 0; drained < 3 && n < 50; n++) step();
    check("pre_reset_drained", drained, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_mem_o_en", mem_o_en, 0);
    step();
    rst = 1'b0;
    step();
    load_frame(2, 1'b0);
    wait_drain(1'b0);

    load_frame(0, 1'b0);
    wait_drain(1'b0);
`ifdef CWB_REPLAY_EN
    in_valid = 1'b1; in_data = DATA_W'(9); replay = 1'b1;
    #1;
    check("replay_blocks_write", mem_rw, 0);
    step();
    replay = 1'b0; in_valid = 1'b0;
    check("replay_no_frame_loaded", frame_loaded, 0);
    wait_drain(1'b0);
`else
    replay = 1'b1;
    step();
    replay = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("replay_ignored_valid", out_valid, 0);
      check("replay_ignored_ready", in_ready, 1);
      step();
    end
`endif

    // Random frames with random gaps and random backpressure.
    for (int f = 0; f < 5; f++) begin
      load_frame(1, 1'b1);
      wait_drain(1'b1);
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
